acc_drain: RTL and testbench



---
 rtl/acc_drain_pkg.sv | 49 ++++
 rtl/acc_fifo.sv | 76 +++++++
 rtl/acc_drain.sv | 117 +++++++++++
 tb/tb_acc_drain.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/acc_drain_pkg.sv
// Shared types and constants for the accumulator drain path.
// ACC_DRAIN_SAT36_EN selects 36-bit saturated, two-word output.
package acc_drain_pkg;

  localparam int WORD_W = 18;
  localparam int RES_W  = 54;

`ifdef ACC_DRAIN_SAT36_EN
  localparam int NWORDS = 2;
`else
  localparam int NWORDS = 3;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W0   = 2'd1,
    W1   = 2'd2,
    W2   = 2'd3
  } drain_state_t;

  localparam drain_state_t LAST_ST = (NWORDS == 2) ? W1 : W2;

  function automatic drain_state_t next_word(input drain_state_t s);
    drain_state_t n;
    case (s)
      IDLE:    n = W0;
      W0:      n = W1;
      W1:      n = W2;
      default: n = IDLE;
    endcase
    return n;
  endfunction

`ifdef ACC_DRAIN_SAT36_EN
  // In range when bits 53..35 are all copies of the sign bit.
  function automatic logic [RES_W-1:0] sat36(input logic [RES_W-1:0] r);
    logic [RES_W-1:0] v;
    if ((&r[RES_W-1:35]) || !(|r[RES_W-1:35])) begin
      v = {18'd0, r[35:0]};
    end else if (r[RES_W-1] == 1'b0) begin
      v = {18'd0, 36'h7_FFFF_FFFF};
    end else begin
      v = {18'd0, 36'h8_0000_0000};
    end
    return v;
  endfunction
`endif

endpackage

// File: rtl/acc_fifo.sv
// Synchronous result FIFO with registered full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module acc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 54
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push && !full_r;
  assign pop_ok_s  = pop && !empty_r;
  assign dout      = mem_r[rd_ptr_r];
  assign full      = full_r;
  assign empty     = empty_r;

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_DEPTH);
      empty_r <= (count_nxt_s == '0);
    end
  end

endmodule

// File: rtl/acc_drain.sv
// Buffers 54-bit accumulator results and serialises them LSB-first as 18-bit words.
// ACC_DRAIN_SAT36_EN: saturate each result to 36 bits and send two words.
module acc_drain
  import acc_drain_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              res_valid,
  input  logic [RES_W-1:0]  res_in,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              full,
  output logic              overflow
);

  logic [RES_W-1:0]  head_s;
  logic [RES_W-1:0]  load_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              push_s;
  logic              pop_s;
  logic              hs_s;
  drain_state_t      state_r;
  logic [RES_W-1:0]  sreg_r;
  logic [WORD_W-1:0] dout_r;
  logic              dout_valid_r;
  logic              dout_last_r;
  logic              overflow_r;

  assign push_s = ena && res_valid && !fifo_full_s;
  assign hs_s   = dout_valid_r && dout_ready;
  // Popping on the last-word handshake chains results without a bubble.
  assign pop_s  = ena && !fifo_empty_s &&
                  ((state_r == IDLE) || (hs_s && (state_r == LAST_ST)));

  acc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RES_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   (res_in),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Value loaded into the serialiser on a pop.
  always_comb begin
`ifdef ACC_DRAIN_SAT36_EN
    load_s = sat36(head_s);
`else
    load_s = head_s;
`endif
  end

  // Sticky overflow: a push attempted while the FIFO was already full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r <= 1'b0;
    end else if (ena && res_valid && fifo_full_s) begin
      overflow_r <= 1'b1;
    end
  end

  // Serialiser FSM; sreg_r holds the words not yet presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      sreg_r       <= '0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      dout_last_r  <= 1'b0;
    end else if (ena) begin
      if (pop_s) begin
        state_r      <= W0;
        sreg_r       <= {{WORD_W{1'b0}}, load_s[RES_W-1:WORD_W]};
        dout_r       <= load_s[WORD_W-1:0];
        dout_valid_r <= 1'b1;
        dout_last_r  <= 1'b0;
      end else if (hs_s) begin
        case (state_r)
          LAST_ST: begin
            state_r      <= IDLE;
            dout_valid_r <= 1'b0;
            dout_last_r  <= 1'b0;
          end
          W0, W1: begin
            state_r     <= next_word(state_r);
            sreg_r      <= sreg_r >> WORD_W;
            dout_r      <= sreg_r[WORD_W-1:0];
            dout_last_r <= (next_word(state_r) == LAST_ST);
          end
          default: begin
            state_r      <= IDLE;
            dout_valid_r <= 1'b0;
            dout_last_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r && ena;
  assign dout_last  = dout_last_r;
  assign full       = fifo_full_s;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_acc_drain.sv
// Directed self-checking bench for acc_drain; honours ACC_DRAIN_SAT36_EN.
module tb_acc_drain;

`ifdef ACC_DRAIN_SAT36_EN
  localparam int NW = 2;
`else
  localparam int NW = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        res_valid;
  logic [53:0] res_in;
  logic [17:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;
  logic        full;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  acc_drain #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .res_valid  (res_valid),
    .res_in     (res_in),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .full       (full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [53:0] obs, input logic [53:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected word i of result r as the sink should see it.
  function automatic logic [17:0] exp_word(input logic [53:0] r, input int i);
    logic [53:0] v;
    v = r;
`ifdef ACC_DRAIN_SAT36_EN
    if ($signed(r) > $signed(54'h0_0007_FFFF_FFFF)) begin
      v = 54'h0_0007_FFFF_FFFF;
    end else if ($signed(r) < $signed(54'h3F_FFF8_0000_0000)) begin
      v = 54'h0_0008_0000_0000;
    end else begin
      v = {18'd0, r[35:0]};
    end
`endif
    return v[i*18 +: 18];
  endfunction

  function automatic logic [53:0] mk(input int k);
    return {18'(3*k+3), 18'(3*k+2), 18'(3*k+1)};
  endfunction

  task automatic push_one(input logic [53:0] v);
    res_valid = 1'b1;
    res_in    = v;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [53:0] r;
    logic [53:0] ra;
    logic [53:0] rd;
    logic        pat [5];
    int          idx;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset held with traffic applied
    rst = 1'b0; ena = 1'b1; res_valid = 1'b1; res_in = 54'h123; dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dout",  54'(dout), 54'd0);
    check("rst_valid", 54'(dout_valid), 54'd0);
    check("rst_last",  54'(dout_last), 54'd0);
    check("rst_full",  54'(full), 54'd0);
    check("rst_ovf",   54'(overflow), 54'd0);
    rst = 1'b1; res_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_valid", 54'(dout_valid), 54'd0);
    end

    // res_valid ignored while disabled
    ena = 1'b0; res_valid = 1'b1; res_in = mk(7);
    repeat (2) @(negedge clk);
    res_valid = 1'b0; ena = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ena0_nopush", 54'(dout_valid), 54'd0);
    end

    // Single result, ready held high
    r = {18'h3, 18'h2, 18'h1};
    push_one(r);
    check("lat_idle", 54'(dout_valid), 54'd0);
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      check("single_word",  54'(dout), 54'(exp_word(r, i)));
      check("single_valid", 54'(dout_valid), 54'd1);
      check("single_last",  54'(dout_last), 54'((i == NW-1) ? 1 : 0));
    end
    @(negedge clk);
    check("single_end", 54'(dout_valid), 54'd0);

    // ena low mid-frame freezes the word and masks dout_valid
    r = mk(10);
    push_one(r);
    @(negedge clk);
    check("frz_w0", 54'(dout), 54'(exp_word(r, 0)));
    ena = 1'b0;
    @(negedge clk);
    check("frz_valid", 54'(dout_valid), 54'd0);
    check("frz_hold",  54'(dout), 54'(exp_word(r, 0)));
    ena = 1'b1;
    for (int i = 1; i < NW; i++) begin
      @(negedge clk);
      check("frz_word", 54'(dout), 54'(exp_word(r, i)));
    end
    @(negedge clk);
    check("frz_end", 54'(dout_valid), 54'd0);

    // Backpressure: ready 1,0,0,1,1
    r = {18'h3, 18'h2, 18'h1};
    push_one(r);
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (idx < NW) begin
        check("bp_word",  54'(dout), 54'(exp_word(r, idx)));
        check("bp_valid", 54'(dout_valid), 54'd1);
      end
      dout_ready = pat[c];
      if (pat[c]) idx++;
    end
    @(negedge clk);
    check("bp_end", 54'(dout_valid), 54'd0);

    // Overflow: first result moves into the serialiser, four fill the FIFO
    dout_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      res_valid = 1'b1;
      res_in    = mk(k);
      @(negedge clk);
      check("ovf_full", 54'(full), 54'((k >= 4) ? 1 : 0));
      check("ovf_flag", 54'(overflow), 54'((k >= 5) ? 1 : 0));
    end
    res_valid  = 1'b0;
    dout_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NW; i++) begin
        check("drain_word",  54'(dout), 54'(exp_word(mk(k), i)));
        check("drain_valid", 54'(dout_valid), 54'd1);
        check("drain_last",  54'(dout_last), 54'((i == NW-1) ? 1 : 0));
        @(negedge clk);
      end
    end
    check("drain_end",    54'(dout_valid), 54'd0);
    check("drain_full",   54'(full), 54'd0);
    check("drain_sticky", 54'(overflow), 54'd1);

    // Reset mid-frame with two results queued
    ra = mk(20);
    res_valid = 1'b1; res_in = ra;
    @(negedge clk);
    res_in = mk(21);
    @(negedge clk);
    res_in = mk(22);
    @(negedge clk);
    res_valid = 1'b0;
    check("mid_w1", 54'(dout), 54'(exp_word(ra, 1)));
    rst = 1'b0;
    #1;
    check("mid_async", 54'(dout_valid), 54'd0);
    @(negedge clk);
    check("mid_full", 54'(full), 54'd0);
    check("mid_ovf",  54'(overflow), 54'd0);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mid_empty", 54'(dout_valid), 54'd0);
    end
    rd = mk(30);
    push_one(rd);
    @(negedge clk);
    check("mid_fresh_w0", 54'(dout), 54'(exp_word(rd, 0)));
    check("mid_fresh_v",  54'(dout_valid), 54'd1);
    repeat (NW) @(negedge clk);

`ifdef ACC_DRAIN_SAT36_EN
    // Saturation of large positive and negative results
    push_one(54'h00_1000_0000_0000);
    @(negedge clk);
    check("satp_w0", 54'(dout), 54'h3FFFF);
    check("satp_l0", 54'(dout_last), 54'd0);
    @(negedge clk);
    check("satp_w1", 54'(dout), 54'h1FFFF);
    check("satp_l1", 54'(dout_last), 54'd1);
    @(negedge clk);
    push_one(54'h3F_F000_0000_0000);
    @(negedge clk);
    check("satn_w0", 54'(dout), 54'h00000);
    @(negedge clk);
    check("satn_w1", 54'(dout), 54'h20000);
    check("satn_l1", 54'(dout_last), 54'd1);
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
